// File: rtl/mem_arbiter_if.sv
// Request/grant bus between two requesters, the arbiter and the memory controller.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if;
  localparam int unsigned COND_W = 3;
  localparam int unsigned LEN_W  = 6;

  logic              rq0_valid;
  logic              rq1_valid;
  logic [COND_W-1:0] rq0_contition;
  logic [COND_W-1:0] rq1_contition;
  logic [LEN_W-1:0]  rq0_length;
  logic [LEN_W-1:0]  rq1_length;
  logic              rq0_grant;
  logic              rq1_grant;
  logic              rq0_done;
  logic              rq1_done;
  logic              rq0_data_done;
  logic              rq1_data_done;
  logic              rq0_err;
  logic              rq1_err;
  logic [COND_W-1:0] mc_contition;
  logic [LEN_W-1:0]  mc_data_length;
  logic              mc_done;
  logic              mc_data_done;

  modport slave (
    input  rq0_valid, rq1_valid, rq0_contition, rq1_contition, rq0_length, rq1_length,
    input  mc_done, mc_data_done,
    output rq0_grant, rq1_grant, rq0_done, rq1_done, rq0_data_done, rq1_data_done,
    output rq0_err, rq1_err, mc_contition, mc_data_length
  );

  modport master (
    output rq0_valid, rq1_valid, rq0_contition, rq1_contition, rq0_length, rq1_length,
    output mc_done, mc_data_done,
    input  rq0_grant, rq1_grant, rq0_done, rq1_done, rq0_data_done, rq1_data_done,
    input  rq0_err, rq1_err, mc_contition, mc_data_length
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter for a single memory controller, with a
// per-transfer watchdog that aborts transfers stuck longer than TIMEOUT cycles.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 200
) (
  input logic           arb_clk,
  input logic           arb_reset,
  mem_arbiter_if.slave  bus
);
  localparam int unsigned COND_W = 3;
  localparam int unsigned LEN_W  = 6;
  localparam int unsigned WD_W   = 8;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    BUSY    = 2'b01,
    RELEASE = 2'b10
  } state_t;

  state_t            state;
  logic [1:0]        grant;
  logic [1:0]        done;
  logic [1:0]        data_done;
  logic [1:0]        err;
  logic [COND_W-1:0] mc_cond;
  logic [LEN_W-1:0]  mc_len;
  logic [WD_W-1:0]   watchdog;
  logic              last;
  logic              owner;

  logic              elig0;
  logic              elig1;
  logic              pick1;
  logic [COND_W-1:0] sel_cond;
  logic [LEN_W-1:0]  sel_len;

  assign elig0 = bus.rq0_valid && (bus.rq0_contition != COND_W'(0));
  assign elig1 = bus.rq1_valid && (bus.rq1_contition != COND_W'(0));
  // Requester 1 wins when alone, or on a tie when requester 0 was granted last.
  assign pick1    = elig1 && (!elig0 || (last == 1'b0));
  assign sel_cond = pick1 ? bus.rq1_contition : bus.rq0_contition;
  assign sel_len  = pick1 ? bus.rq1_length    : bus.rq0_length;

  always_ff @(posedge arb_clk or posedge arb_reset) begin
    if (arb_reset) begin
      state     <= IDLE;
      grant     <= 2'b00;
      done      <= 2'b00;
      data_done <= 2'b00;
      err       <= 2'b00;
      mc_cond   <= COND_W'(0);
      mc_len    <= LEN_W'(0);
      watchdog  <= WD_W'(0);
      last      <= 1'b1;
      owner     <= 1'b0;
    end else begin
      done      <= 2'b00;
      data_done <= 2'b00;
      err       <= 2'b00;
      case (state)
        IDLE: begin
          if (elig0 || elig1) begin
            state    <= BUSY;
            grant    <= pick1 ? 2'b10 : 2'b01;
            owner    <= pick1;
            last     <= pick1;
            mc_cond  <= sel_cond;
            mc_len   <= sel_len;
            watchdog <= WD_W'(0);
          end
        end
        BUSY: begin
          // Completion takes priority over a watchdog expiry in the same cycle.
          if (bus.mc_done) begin
            state            <= RELEASE;
            done[owner]      <= 1'b1;
            data_done[owner] <= bus.mc_data_done;
            grant            <= 2'b00;
            mc_cond          <= COND_W'(0);
          end else if (watchdog == WD_LIMIT) begin
            state      <= RELEASE;
            err[owner] <= 1'b1;
            grant      <= 2'b00;
            mc_cond    <= COND_W'(0);
            watchdog   <= watchdog + WD_W'(1);
          end else begin
            watchdog <= watchdog + WD_W'(1);
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          grant     <= 2'b00;
          mc_cond   <= COND_W'(0);
          mc_len    <= LEN_W'(0);
          watchdog  <= WD_W'(0);
          last      <= 1'b1;
          owner     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rq0_grant      = grant[0];
  assign bus.rq1_grant      = grant[1];
  assign bus.rq0_done       = done[0];
  assign bus.rq1_done       = done[1];
  assign bus.rq0_data_done  = data_done[0];
  assign bus.rq1_data_done  = data_done[1];
  assign bus.rq0_err        = err[0];
  assign bus.rq1_err        = err[1];
  assign bus.mc_contition   = mc_cond;
  assign bus.mc_data_length = mc_len;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (default and TIMEOUT=4) share stimulus;
// a transaction-level model predicts winner, latching and done/err outcome.
module tb_mem_arbiter;
  localparam int unsigned SHORT_TO = 4;
  localparam int unsigned LONG_TO  = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rq0_valid = 1'b0, rq1_valid = 1'b0;
  logic [2:0] rq0_contition = 3'b000, rq1_contition = 3'b000;
  logic [5:0] rq0_length = 6'd0, rq1_length = 6'd0;
  logic       mc_done = 1'b0, mc_data_done = 1'b0;
  logic       sel_t = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int m_last  = 1;

  mem_arbiter_if bus();
  mem_arbiter_if bus_t();

  mem_arbiter #(.TIMEOUT(LONG_TO))  dut   (.arb_clk(clk), .arb_reset(rst), .bus(bus));
  mem_arbiter #(.TIMEOUT(SHORT_TO)) dut_t (.arb_clk(clk), .arb_reset(rst), .bus(bus_t));

  assign bus.rq0_valid       = rq0_valid;
  assign bus.rq1_valid       = rq1_valid;
  assign bus.rq0_contition   = rq0_contition;
  assign bus.rq1_contition   = rq1_contition;
  assign bus.rq0_length      = rq0_length;
  assign bus.rq1_length      = rq1_length;
  assign bus.mc_done         = mc_done;
  assign bus.mc_data_done    = mc_data_done;
  assign bus_t.rq0_valid     = rq0_valid;
  assign bus_t.rq1_valid     = rq1_valid;
  assign bus_t.rq0_contition = rq0_contition;
  assign bus_t.rq1_contition = rq1_contition;
  assign bus_t.rq0_length    = rq0_length;
  assign bus_t.rq1_length    = rq1_length;
  assign bus_t.mc_done       = mc_done;
  assign bus_t.mc_data_done  = mc_data_done;

  logic [1:0] o_grant, o_done, o_ddone, o_err;
  logic [2:0] o_cond;
  logic [5:0] o_len;
  assign o_grant = sel_t ? {bus_t.rq1_grant, bus_t.rq0_grant} : {bus.rq1_grant, bus.rq0_grant};
  assign o_done  = sel_t ? {bus_t.rq1_done, bus_t.rq0_done} : {bus.rq1_done, bus.rq0_done};
  assign o_ddone = sel_t ? {bus_t.rq1_data_done, bus_t.rq0_data_done}
                         : {bus.rq1_data_done, bus.rq0_data_done};
  assign o_err   = sel_t ? {bus_t.rq1_err, bus_t.rq0_err} : {bus.rq1_err, bus.rq0_err};
  assign o_cond  = sel_t ? bus_t.mc_contition : bus.mc_contition;
  assign o_len   = sel_t ? bus_t.mc_data_length : bus.mc_data_length;

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL sim_timeout: simulation did not finish, required finish before 2ms");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rq0_valid = 1'b0; rq1_valid = 1'b0;
    rq0_contition = 3'b000; rq1_contition = 3'b000;
    rq0_length = 6'd0; rq1_length = 6'd0;
    mc_done = 1'b0; mc_data_done = 1'b0;
    rst = 1'b1;
    #2;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_last = 1;
  endtask

  // One arbitration from IDLE through RELEASE; delay = BUSY cycles before mc_done.
  task automatic run_txn(input logic v0, input logic v1, input logic [2:0] c0, input logic [2:0] c1,
                         input logic [5:0] l0, input logic [5:0] l1, input int delay,
                         input logic dd, input bit perturb, input string tag);
    logic e0, e1, ok_done;
    int w, to, end_k;
    logic [1:0] eg;
    logic [2:0] ec;
    logic [5:0] el;
    e0 = v0 && (c0 != 3'b000);
    e1 = v1 && (c1 != 3'b000);
    to = sel_t ? SHORT_TO : LONG_TO;
    rq0_valid = v0; rq1_valid = v1;
    rq0_contition = c0; rq1_contition = c1;
    rq0_length = l0; rq1_length = l1;
    mc_done = 1'b0; mc_data_done = 1'b0;
    tick();
    if (!e0 && !e1) begin
      n_tests++;
      if ({o_grant, o_cond, o_done, o_err} !== 9'd0) begin
        n_fail++;
        $display("FAIL %s idle_hold: grant=%b cond=%b done=%b err=%b, required all zero",
                 tag, o_grant, o_cond, o_done, o_err);
      end
      return;
    end
    if (e0 && e1) w = (m_last == 0) ? 1 : 0;
    else          w = e0 ? 0 : 1;
    m_last = w;
    eg = (w == 0) ? 2'b01 : 2'b10;
    ec = (w == 0) ? c0 : c1;
    el = (w == 0) ? l0 : l1;
    n_tests++;
    if ({o_grant, o_cond, o_len} !== {eg, ec, el}) begin
      n_fail++;
      $display("FAIL %s grant: grant=%b cond=%b len=%0d, required grant=%b cond=%b len=%0d",
               tag, o_grant, o_cond, o_len, eg, ec, el);
    end
    ok_done = (delay + 1 <= to);
    end_k   = ok_done ? delay + 1 : to;
    if (perturb) begin
      rq0_valid = 1'($urandom); rq1_valid = 1'($urandom);
      rq0_contition = 3'($urandom); rq1_contition = 3'($urandom);
      rq0_length = 6'($urandom); rq1_length = 6'($urandom);
    end
    for (int k = 1; k <= end_k; k++) begin
      mc_done      = (k == delay + 1);
      mc_data_done = (k == delay + 1) ? dd : 1'($urandom);
      tick();
      n_tests++;
      if (k < end_k) begin
        if ({o_grant, o_cond, o_len, o_done, o_err, o_ddone} !== {eg, ec, el, 6'd0}) begin
          n_fail++;
          $display("FAIL %s busy_c%0d: grant=%b cond=%b len=%0d done=%b err=%b dd=%b, required %b %b %0d 00 00 00",
                   tag, k, o_grant, o_cond, o_len, o_done, o_err, o_ddone, eg, ec, el);
        end
      end else begin
        if ({o_grant, o_cond, o_done, o_err, o_ddone} !==
            {2'b00, 3'b000, ok_done ? eg : 2'b00, ok_done ? 2'b00 : eg, (ok_done && dd) ? eg : 2'b00}) begin
          n_fail++;
          $display("FAIL %s end: grant=%b cond=%b done=%b err=%b dd=%b, required done=%0d err=%0d owner=%0d dd=%b",
                   tag, o_grant, o_cond, o_done, o_err, o_ddone, ok_done, !ok_done, w, dd);
        end
      end
    end
    mc_done = 1'b0; mc_data_done = 1'b0;
    tick();
    n_tests++;
    if ({o_grant, o_cond, o_done, o_err, o_ddone} !== 11'd0) begin
      n_fail++;
      $display("FAIL %s release: grant=%b cond=%b done=%b err=%b dd=%b, required all zero",
               tag, o_grant, o_cond, o_done, o_err, o_ddone);
    end
  endtask

  task automatic test_reset();
    sel_t = 1'b0;
    rst = 1'b1;
    #3;
    n_tests++;
    if ({bus.rq0_grant, bus.rq1_grant, bus.rq0_done, bus.rq1_done, bus.rq0_err, bus.rq1_err,
         bus.rq0_data_done, bus.rq1_data_done, bus.mc_contition, bus.mc_data_length,
         bus_t.rq0_grant, bus_t.rq1_grant, bus_t.mc_contition, bus_t.mc_data_length} !== 29'd0) begin
      n_fail++;
      $display("FAIL reset_values: outputs not cleared, cond=%b len=%0d, required all zero",
               bus.mc_contition, bus.mc_data_length);
    end
    do_reset();
    tick();
    n_tests++;
    if ({o_grant, o_cond, o_len} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_idle: grant=%b cond=%b len=%0d, required zero", o_grant, o_cond, o_len);
    end
  endtask

  task automatic test_single();
    sel_t = 1'b0;
    do_reset();
    run_txn(1, 0, 3'b100, 3'b000, 6'd12, 6'd0, 5, 1'b0, 0, "single");
  endtask

  task automatic test_round_robin();
    sel_t = 1'b0;
    do_reset();
    run_txn(1, 1, 3'b100, 3'b010, 6'd7, 6'd9, 1, 1'b1, 0, "rr_1");
    run_txn(1, 1, 3'b100, 3'b010, 6'd7, 6'd9, 0, 1'b0, 0, "rr_2");
    run_txn(1, 1, 3'b100, 3'b010, 6'd7, 6'd9, 2, 1'b1, 0, "rr_3");
  endtask

  task automatic test_timeout();
    sel_t = 1'b1;
    do_reset();
    run_txn(0, 1, 3'b000, 3'b001, 6'd0, 6'd40, 1000, 1'b1, 0, "timeout");
    run_txn(1, 0, 3'b010, 3'b000, 6'd63, 6'd0, 0, 1'b1, 0, "after_timeout");
  endtask

  task automatic test_done_wins();
    sel_t = 1'b1;
    do_reset();
    run_txn(1, 0, 3'b001, 3'b000, 6'd5, 6'd0, SHORT_TO - 1, 1'b1, 0, "done_at_limit");
    run_txn(0, 1, 3'b000, 3'b100, 6'd0, 6'd6, SHORT_TO, 1'b1, 0, "done_past_limit");
  endtask

  task automatic test_data_done();
    sel_t = 1'b0;
    do_reset();
    run_txn(1, 0, 3'b010, 3'b000, 6'd3, 6'd0, 2, 1'b0, 0, "ddone_0");
    run_txn(1, 0, 3'b010, 3'b000, 6'd3, 6'd0, 2, 1'b1, 0, "ddone_1");
  endtask

  task automatic test_reset_busy();
    sel_t = 1'b0;
    do_reset();
    rq0_valid = 1'b1; rq0_contition = 3'b100; rq0_length = 6'd21;
    tick();
    n_tests++;
    if ({o_grant, o_cond, o_len} !== {2'b01, 3'b100, 6'd21}) begin
      n_fail++;
      $display("FAIL rstbusy_grant: grant=%b cond=%b len=%0d, required 01 100 21", o_grant, o_cond, o_len);
    end
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({o_grant, o_cond, o_len, o_done, o_err, o_ddone} !== 17'd0) begin
      n_fail++;
      $display("FAIL rstbusy_async: grant=%b cond=%b len=%0d done=%b err=%b, required all zero",
               o_grant, o_cond, o_len, o_done, o_err);
    end
    rq0_valid = 1'b0; rq0_contition = 3'b000;
    mc_done = 1'b1; mc_data_done = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_last = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if ({o_grant, o_done, o_err, o_ddone} !== 8'd0) begin
        n_fail++;
        $display("FAIL rstbusy_silent_c%0d: grant=%b done=%b err=%b dd=%b, required zero",
                 i, o_grant, o_done, o_err, o_ddone);
      end
    end
    run_txn(1, 1, 3'b001, 3'b100, 6'd44, 6'd2, 1, 1'b0, 0, "rstbusy_next");
  endtask

  task automatic test_random();
    logic [2:0] codes [4];
    codes[0] = 3'b000; codes[1] = 3'b001; codes[2] = 3'b010; codes[3] = 3'b100;
    for (int pass = 0; pass < 2; pass++) begin
      sel_t = (pass == 0);
      do_reset();
      for (int n = 0; n < 40; n++) begin
        run_txn(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                codes[$urandom_range(0, 3)], codes[$urandom_range(0, 3)],
                6'($urandom), 6'($urandom), int'($urandom_range(0, 6)),
                1'($urandom), 1, $sformatf("rand_p%0d_n%0d", pass, n));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_done_wins();
    test_data_done();
    test_reset_busy();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 200, is the maximum number of BUSY cycles allowed before a transfer is aborted; legal range 1..255.
REQ-002 arb_clk  input  1  single clock; all state changes on its rising edge.
REQ-003 arb_reset  input  1  reset, asynchronous and active-high.
REQ-004 rq0_valid, rq1_valid  input  1 each  requester has a transfer pending; held until its done or err pulse.
REQ-005 rq0_contition, rq1_contition  input  3 each  requested data condition: 100 store, 010 mem-to-reg, 001 processing; 000 means no request.
REQ-006 rq0_length, rq1_length  input  6 each  transfer length in words.
REQ-007 rq0_grant, rq1_grant  output  1 each  requester currently owns the memory controller.
REQ-008 rq0_done, rq1_done  output  1 each  one-cycle pulse: granted transfer completed.
REQ-009 rq0_data_done, rq1_data_done  output  1 each  copy of mc_data_done, valid only in the cycle of the matching done pulse.
REQ-010 rq0_err, rq1_err  output  1 each  one-cycle pulse: granted transfer aborted on timeout.
REQ-011 mc_contition  output  3  data condition driven to the memory controller.
REQ-012 mc_data_length  output  6  length driven to the memory controller.
REQ-013 mc_done, mc_data_done  input  1 each  completion flags from the memory controller.

Function
REQ-014 States: IDLE, BUSY, RELEASE; 2-bit encoded; unused encodings return to IDLE with all outputs at reset values.
REQ-015 A request is eligible only when rqN_valid=1 and rqN_contition!=000.
REQ-016 IDLE, one eligible requester: at the next edge, grant it, latch its contition/length onto mc_contition/mc_data_length, clear the watchdog, and go to BUSY.
REQ-017 IDLE, both eligible: grant the requester not granted last (round-robin); after reset, requester 0 wins the first tie.
REQ-018 IDLE, none eligible: hold; mc_contition=000 and both grants=0.
REQ-019 Grant and mc outputs are registered; latency is 1 cycle from an eligible request to grant.
REQ-020 BUSY: mc_contition and mc_data_length stay stable; requester inputs are ignored, including valid dropping or contition changing.
REQ-021 BUSY: the 8-bit watchdog increments each cycle mc_done=0.
REQ-022 BUSY, mc_done=1: next edge pulses rqN_done and sets rqN_data_done=mc_data_done; clears grant and mc_contition to 000; goes to RELEASE.
REQ-023 BUSY, watchdog==TIMEOUT-1 and mc_done=0: next edge pulses rqN_err; clears grant and mc_contition; goes to RELEASE.
REQ-024 mc_done=1 in the same cycle the watchdog reaches TIMEOUT-1: completion wins; done pulses, err does not.
REQ-025 RELEASE lasts exactly one cycle with mc_contition=000 and no grant, then returns to IDLE; requests are not sampled in RELEASE.
REQ-026 The last-granted pointer updates when a grant is issued, not on completion.
REQ-027 At most one grant, one done and one err are asserted in any cycle; done and err never assert together.
REQ-028 mc_data_length passes through unmodified: 6 bits, no arithmetic.

Reset
REQ-029 arb_reset=1 immediately forces: state IDLE; all grants, done, data_done and err = 0; mc_contition=000; mc_data_length=0; watchdog=0; last-granted pointer=1 (requester 0 favoured).
REQ-030 Reset asserted in BUSY aborts the transfer silently, with no done or err pulse; the first eligible request after release is arbitrated from IDLE.

Verification
REQ-031 rq0 valid, contition 100, length 12; mc_done 5 cycles after grant -> rq0_grant at cycle +1, mc_contition=100, mc_data_length=12; rq0_done pulses 1 cycle; mc_contition 000 during RELEASE.
REQ-032 rq0 and rq1 valid in the same cycle from reset, each re-requesting immediately -> grant order rq0, rq1, rq0; one RELEASE cycle between grants.
REQ-033 TIMEOUT=4, mc_done never asserted -> rq1_err pulses at the edge after the 4th BUSY cycle; no rq1_done; state returns to IDLE.
REQ-034 mc_done and watchdog limit reached in the same cycle -> rqN_done=1, rqN_err=0.
REQ-035 mc_data_done=0 then 1 on successive transfers of rq0 (contition 010 then 010) -> rq0_data_done is 0 then 1, each coincident with its rq0_done pulse.
REQ-036 arb_reset pulsed mid-BUSY -> outputs clear asynchronously; no done or err pulse; the next request is granted after 1 cycle.
